// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide memory port among NUM_CH cache requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module mem_port_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int LINE_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_read,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*LINE_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        grant,
  output logic [NUM_CH-1:0]        done,
  output logic [LINE_W-1:0]        rdata,
  output logic                     readM,
  output logic                     writeM,
  output logic [ADDR_W-1:0]        address,
  output logic [LINE_W-1:0]        data_out,
  input  logic [LINE_W-1:0]        data_in,
  input  logic                     read_ack,
  input  logic                     write_ack
);
  localparam int IW = $clog2(NUM_CH);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d, done_q, done_d;
  logic [LINE_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic readm_q, readm_d, writem_q, writem_d;
  logic [NUM_CH-1:0] any_req;
  logic found;
  logic [IW-1:0] win;
  assign any_req = req_read | req_write;
`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] last_q, last_d;
  // Descending scan so the channel nearest last_owner+1 is assigned last and wins.
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = NUM_CH; k >= 1; k--)
      if (any_req[(int'(last_q) + k) % NUM_CH]) begin
        found = 1'b1;
        win = IW'((int'(last_q) + k) % NUM_CH);
      end
  end
  always_comb last_d = (state_q == IDLE && found) ? win : last_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_q <= IW'(NUM_CH - 1);
    else last_q <= last_d;
`else
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (any_req[i]) begin
        found = 1'b1;
        win = IW'(i);
      end
  end
`endif
  // In BUSY, writem_q doubles as the registered op: a write wins over a read on the same channel.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d = '0;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    addr_d = addr_q;
    readm_d = readm_q;
    writem_d = writem_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = BUSY;
        grant_d = {{(NUM_CH-1){1'b0}}, 1'b1} << win;
        addr_d = req_addr[int'(win)*ADDR_W +: ADDR_W];
        wdata_d = req_wdata[int'(win)*LINE_W +: LINE_W];
        writem_d = req_write[win];
        readm_d = !req_write[win];
      end
      BUSY: if (writem_q ? write_ack : read_ack) begin
        state_d = RESP;
        done_d = grant_q;
        readm_d = 1'b0;
        writem_d = 1'b0;
        rdata_d = writem_q ? rdata_q : data_in;
      end
      RESP: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q <= '0;
      readm_q <= 1'b0;
      writem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q <= done_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      addr_q <= addr_d;
      readm_q <= readm_d;
      writem_q <= writem_d;
    end
  assign grant = grant_q;
  assign done = done_q;
  assign rdata = rdata_q;
  assign readM = readm_q;
  assign writeM = writem_q;
  assign address = addr_q;
  assign data_out = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus corner-case sequences for mem_port_arbiter (NUM_CH=4),
// with a done/rdata scoreboard; expected contention order follows MEM_ARB_RR_EN.
module tb_mem_port_arbiter;
  localparam int N = 4, AW = 16, LW = 64;
  logic clk = 0, reset = 1;
  logic [N-1:0] req_read = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_wdata = '0;
  logic [LW-1:0] data_in = '0;
  logic read_ack = 0, write_ack = 0;
  logic [N-1:0] grant, done;
  logic [LW-1:0] rdata, data_out;
  logic readM, writeM;
  logic [AW-1:0] address;

  mem_port_arbiter #(.NUM_CH(N), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done),
    .rdata(rdata), .readM(readM), .writeM(writeM), .address(address),
    .data_out(data_out), .data_in(data_in), .read_ack(read_ack), .write_ack(write_ack)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; bit wr; logic [AW-1:0] addr; logic [LW-1:0] wdata; logic [LW-1:0] rd; int dly; } vec_t;
  typedef struct { logic [N-1:0] done; logic [LW-1:0] rdata; } exp_t;
  vec_t vecs[5];
  exp_t sb[$];
  int tests = 0, fails = 0;
  logic [LW-1:0] model_rd = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done != '0) begin
      if (sb.size() == 0) chk("spurious_done", done, 0);
      else begin
        e = sb.pop_front();
        chk("sb_done", done, e.done);
        chk("sb_rdata", rdata, e.rdata);
      end
    end
  end

  task automatic wait_grant(input string nm);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (grant == '0 && n < 12);
    if (grant == '0) begin
      tests++; fails++;
      $display("FAIL %s_grant_timeout: got none expected a grant", nm);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    model_rd = '0;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic finish_txn(input int ch, input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] rd, input int dly);
    repeat (dly) begin
      @(posedge clk); #1;
      chk("busy_strobe", {readM, writeM}, wr ? 2'b01 : 2'b10);
      chk("busy_addr", address, addr);
    end
    if (wr) write_ack = 1;
    else begin read_ack = 1; data_in = rd; model_rd = rd; end
    sb.push_back('{N'(1) << ch, model_rd});
    @(posedge clk); #1;
    read_ack = 0; write_ack = 0; data_in = '0;
    chk("resp_strobe", {readM, writeM}, 0);
    chk("resp_grant", grant, 1 << ch);
    if (wr) req_write[ch] = 0; else req_read[ch] = 0;
    @(posedge clk); #1;
    chk("idle_grant", grant, 0);
  endtask

  task automatic run_vec(input vec_t v);
    req_addr[v.ch*AW +: AW] = v.addr;
    req_wdata[v.ch*LW +: LW] = v.wdata;
    if (v.wr) req_write[v.ch] = 1; else req_read[v.ch] = 1;
    wait_grant("vec");
    chk("vec_grant", grant, 1 << v.ch);
    chk("vec_strobe", {readM, writeM}, v.wr ? 2'b01 : 2'b10);
    chk("vec_addr", address, v.addr);
    if (v.wr) chk("vec_data_out", data_out, v.wdata);
    req_addr[v.ch*AW +: AW] = ~v.addr;
    req_wdata[v.ch*LW +: LW] = ~v.wdata;
    finish_txn(v.ch, v.wr, v.addr, v.rd, v.dly);
    if (v.wr) chk("vec_data_hold", data_out, v.wdata);
  endtask

  initial begin
    vecs[0] = '{1, 1'b0, 16'h0040, 64'h0, 64'h1111_2222_3333_4444, 3};
    vecs[1] = '{0, 1'b1, 16'h0100, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 0};
    vecs[2] = '{2, 1'b0, 16'h1234, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0};
    vecs[3] = '{3, 1'b1, 16'hFFFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1};
    vecs[4] = '{0, 1'b0, 16'h0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_strobe", {readM, writeM}, 0);
    chk("rst_address", address, 0);
    chk("rst_data_out", data_out, 0);
    reset = 0;
    foreach (vecs[i]) run_vec(vecs[i]);

    // Same channel read+write: write first, read afterwards
    req_addr[0 +: AW] = 16'h0100;
    req_wdata[0 +: LW] = 64'hAAAA_BBBB_CCCC_DDDD;
    req_read[0] = 1; req_write[0] = 1;
    wait_grant("rw");
    chk("rw_first_strobe", {readM, writeM}, 2'b01);
    chk("rw_data_out", data_out, 64'hAAAA_BBBB_CCCC_DDDD);
    finish_txn(0, 1, 16'h0100, 0, 0);
    wait_grant("rw2");
    chk("rw_second_grant", grant, 1);
    chk("rw_second_strobe", {readM, writeM}, 2'b10);
    chk("rw_second_addr", address, 16'h0100);
    finish_txn(0, 0, 16'h0100, 64'h5555_6666_7777_8888, 1);

    // Wrong-type ack during a read is ignored
    req_addr[AW +: AW] = 16'h0200;
    req_read[1] = 1;
    wait_grant("wrong");
    write_ack = 1;
    @(posedge clk); #1;
    write_ack = 0;
    chk("wrong_ack_strobe", {readM, writeM}, 2'b10);
    chk("wrong_ack_grant", grant, 2);
    chk("wrong_ack_done", done, 0);
    finish_txn(1, 0, 16'h0200, 64'h0BAD_F00D_1234_5678, 0);

    // Spurious read_ack in IDLE is ignored
    read_ack = 1; data_in = 64'h9999_9999_9999_9999;
    @(posedge clk); #1;
    read_ack = 0; data_in = '0;
    chk("idle_ack_grant", grant, 0);
    chk("idle_ack_strobe", {readM, writeM}, 0);
    chk("idle_ack_rdata", rdata, model_rd);
    @(posedge clk); #1;
    chk("idle_ack_done", done, 0);

    // Contention between ch0 and ch1 for four transfers
    do_reset();
    req_addr[0 +: AW] = 16'h0A00;
    req_addr[AW +: AW] = 16'h0B00;
    for (int t = 0; t < 4; t++) begin
      int ec;
`ifdef MEM_ARB_RR_EN
      ec = t % 2;
`else
      ec = 0;
`endif
      req_read[0] = 1; req_read[1] = 1;
      wait_grant("cont");
      chk($sformatf("cont_grant_%0d", t), grant, 1 << ec);
      finish_txn(ec, 0, ec ? 16'h0B00 : 16'h0A00, 64'h1000 + 64'(t), 0);
    end
    req_read = '0;
    @(posedge clk); #1;

    // Reset between edges during a read, then all four request
    req_addr[2*AW +: AW] = 16'h2222;
    req_read[2] = 1;
    wait_grant("rst_mid");
    #2 reset = 1;
    #1;
    chk("rst_mid_readM", readM, 0);
    chk("rst_mid_grant", grant, 0);
    model_rd = '0;
    req_read = '1;
    @(posedge clk); #1;
    reset = 0;
    wait_grant("post_rst");
    chk("post_rst_grant", grant, 1);
    chk("post_rst_rdata", rdata, 0);
    req_read = 4'b0001;
    finish_txn(0, 0, 16'h0A00, 64'h4242_4242_4242_4242, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
